// File: rtl/apb_pkg.sv
// Shared constants for the APB register slave: FSM encoding, default bus widths
// and the wait-state counter type.
package apb_pkg;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W register storage with one write port, a combinational read
// port and asynchronous clear on preset.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [IDX_W-1:0]  ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end

  assign rd = mem_q[ra];

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with a DEPTH-entry register file and WAIT_STATES wait cycles per transfer.
// Define APB_SLVERR_EN to report out-of-range accesses on pslverr (tied low otherwise).
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddress,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam cnt_t            WS_LOAD = CNT_W'(WAIT_STATES);

  logic [0:0]        state_q;
  cnt_t              cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wd_q;

  logic              setup;
  logic              in_range;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  // A SETUP phase (psel high, penable low) restarts the transfer in either state.
  assign setup    = psel && !penable;
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign pready   = (state_q == ACCESS) && (cnt_q == '0);
  assign wr_en    = pready && psel && penable && wr_q && in_range;

  always_ff @(posedge clk or negedge preset) begin
    if (!preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wd_q    <= '0;
    end else if (setup) begin
      state_q <= ACCESS;
      cnt_q   <= WS_LOAD;
      addr_q  <= paddress;
      wr_q    <= pwrite;
      wd_q    <= pwdata;
    end else if (state_q == ACCESS) begin
      if (!psel) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (cnt_q == '0) begin
        state_q <= IDLE;
      end else begin
        cnt_q <= cnt_q - cnt_t'(1);
      end
    end
  end

  apb_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk    (clk),
    .preset (preset),
    .we     (wr_en),
    .wa     (addr_q[IDX_W-1:0]),
    .wd     (wd_q),
    .ra     (addr_q[IDX_W-1:0]),
    .rd     (rd_data)
  );

  assign prdata = (pready && !wr_q && in_range) ? rd_data : '0;

`ifdef APB_SLVERR_EN
  assign pslverr = pready && !in_range;
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one instance with one wait state, one zero-wait.
module tb_apb_reg_slave;

  logic       clk = 1'b0;
  logic       preset;
  logic       psel0, psel1, penable, pwrite;
  logic [7:0] paddress, pwdata;
  logic       pready0, pready1, pslverr0, pslverr1;
  logic [7:0] prdata0, prdata1;

  int n_vec = 0;
  int n_err = 0;

`ifdef APB_SLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  apb_reg_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_STATES(1)) dut1 (
    .clk(clk), .preset(preset), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddress(paddress), .pwdata(pwdata), .pready(pready1), .prdata(prdata1),
    .pslverr(pslverr1)
  );

  apb_reg_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddress(paddress), .pwdata(pwdata), .pready(pready0), .prdata(prdata0),
    .pslverr(pslverr0)
  );

  // One full transfer starting in the current cycle (SETUP = cycle 1). Address-phase
  // inputs are scrambled during ACCESS. Returns the cycle in which pready was seen,
  // prdata/pslverr in that cycle, and pready in the IDLE cycle afterwards.
  task automatic xfer(input bit use0, input logic wr, input logic [7:0] addr,
                      input logic [7:0] data, output int cycles, output logic [7:0] rd,
                      output logic err, output logic post_rdy);
    psel0 = use0; psel1 = !use0; penable = 1'b0;
    pwrite = wr; paddress = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1; pwrite = ~wr; paddress = ~addr; pwdata = ~data;
    cycles = 2;
    while (!(use0 ? pready0 : pready1) && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    rd  = use0 ? prdata0 : prdata1;
    err = use0 ? pslverr0 : pslverr1;
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    post_rdy = use0 ? pready0 : pready1;
  endtask

  task automatic test_reset();
    int cyc; logic [7:0] rd; logic err, post;
    preset = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddress = '0; pwdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (pready1 !== 1'b0) begin n_err++; $display("FAIL reset_pready got=%b want=0", pready1); end
    n_vec++; if (prdata1 !== 8'h00) begin n_err++; $display("FAIL reset_prdata got=%h want=00", prdata1); end
    n_vec++; if (pslverr1 !== 1'b0) begin n_err++; $display("FAIL reset_pslverr got=%b want=0", pslverr1); end
    preset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({pready1, pready0} !== 2'b00) begin n_err++; $display("FAIL post_reset_pready got=%b want=00", {pready1, pready0}); end
    xfer(1'b0, 1'b0, 8'h05, 8'h00, cyc, rd, err, post);
    n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL reset_read05 got=%h want=00", rd); end
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL reset_read_latency got=%0d want=3", cyc); end
  endtask

  task automatic test_write_read();
    int cyc; logic [7:0] rd; logic err, post;
    xfer(1'b0, 1'b1, 8'h03, 8'hA5, cyc, rd, err, post);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL wr_latency got=%0d want=3", cyc); end
    n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL wr_prdata got=%h want=00", rd); end
    n_vec++; if (post !== 1'b0) begin n_err++; $display("FAIL wr_idle_pready got=%b want=0", post); end
    xfer(1'b0, 1'b0, 8'h03, 8'h00, cyc, rd, err, post);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL rd_latency got=%0d want=3", cyc); end
    n_vec++; if (rd !== 8'hA5) begin n_err++; $display("FAIL rd03 got=%h want=a5", rd); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rd03_pslverr got=%b want=0", err); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [7:0] rd; logic err, post;
    logic [7:0] addrs [4] = '{8'h00, 8'h01, 8'h00, 8'h01};
    logic [7:0] dats  [4] = '{8'h11, 8'h22, 8'h00, 8'h00};
    logic [7:0] exps  [4] = '{8'h00, 8'h00, 8'h11, 8'h22};
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, (i < 2), addrs[i], dats[i], cyc, rd, err, post);
      n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL b2b_latency[%0d] got=%0d want=2", i, cyc); end
      n_vec++; if (rd !== exps[i]) begin n_err++; $display("FAIL b2b_prdata[%0d] got=%h want=%h", i, rd, exps[i]); end
      n_vec++; if (post !== 1'b0) begin n_err++; $display("FAIL b2b_idle[%0d] got=%b want=0", i, post); end
    end
  endtask

  task automatic test_abort();
    int cyc; logic [7:0] rd; logic err, post;
    xfer(1'b0, 1'b1, 8'h02, 8'h3C, cyc, rd, err, post);
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddress = 8'h02; pwdata = 8'h7E;
    @(posedge clk); #1;
    penable = 1'b1;
    n_vec++; if (pready1 !== 1'b0) begin n_err++; $display("FAIL abort_wait_pready got=%b want=0", pready1); end
    psel1 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_vec++; if (pready1 !== 1'b0) begin n_err++; $display("FAIL abort_pready[%0d] got=%b want=0", i, pready1); end
    end
    xfer(1'b0, 1'b0, 8'h02, 8'h00, cyc, rd, err, post);
    n_vec++; if (rd !== 8'h3C) begin n_err++; $display("FAIL abort_rd02 got=%h want=3c", rd); end
  endtask

  task automatic test_resetup();
    int cyc; logic [7:0] rd; logic err, post;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddress = 8'h04; pwdata = 8'h99;
    @(posedge clk); #1;
    paddress = 8'h05; pwdata = 8'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    n_vec++; if (pready1 !== 1'b0) begin n_err++; $display("FAIL resetup_wait got=%b want=0", pready1); end
    @(posedge clk); #1;
    n_vec++; if (pready1 !== 1'b1) begin n_err++; $display("FAIL resetup_ready got=%b want=1", pready1); end
    @(posedge clk); #1;
    psel1 = 1'b0; penable = 1'b0;
    xfer(1'b0, 1'b0, 8'h05, 8'h00, cyc, rd, err, post);
    n_vec++; if (rd !== 8'h77) begin n_err++; $display("FAIL resetup_rd05 got=%h want=77", rd); end
    xfer(1'b0, 1'b0, 8'h04, 8'h00, cyc, rd, err, post);
    n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL resetup_rd04 got=%h want=00", rd); end
  endtask

  task automatic test_out_of_range();
    int cyc; logic [7:0] rd; logic err, post;
    xfer(1'b0, 1'b1, 8'h20, 8'h55, cyc, rd, err, post);
    n_vec++; if (cyc !== 3) begin n_err++; $display("FAIL oor_wr_latency got=%0d want=3", cyc); end
    n_vec++; if (err !== EXP_ERR) begin n_err++; $display("FAIL oor_wr_pslverr got=%b want=%b", err, EXP_ERR); end
    xfer(1'b0, 1'b0, 8'h20, 8'h00, cyc, rd, err, post);
    n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL oor_rd20 got=%h want=00", rd); end
    n_vec++; if (err !== EXP_ERR) begin n_err++; $display("FAIL oor_rd_pslverr got=%b want=%b", err, EXP_ERR); end
    xfer(1'b0, 1'b0, 8'h00, 8'h00, cyc, rd, err, post);
    n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL oor_alias_rd00 got=%h want=00", rd); end
  endtask

  task automatic test_reset_mid();
    int cyc; logic [7:0] rd; logic err, post;
    logic [7:0] raddr [4] = '{8'h03, 8'h02, 8'h05, 8'h07};
    // Reset while the zero-wait slave is presenting read data.
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddress = 8'h01;
    @(posedge clk); #1;
    penable = 1'b1;
    n_vec++; if (prdata0 !== 8'h22) begin n_err++; $display("FAIL mid_pre_prdata got=%h want=22", prdata0); end
    #2 preset = 1'b0;
    #1;
    n_vec++; if (pready0 !== 1'b0) begin n_err++; $display("FAIL mid_async_pready got=%b want=0", pready0); end
    n_vec++; if (prdata0 !== 8'h00) begin n_err++; $display("FAIL mid_async_prdata got=%h want=00", prdata0); end
    psel0 = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    preset = 1'b1;
    // Reset during a wait cycle of a pending write.
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddress = 8'h07; pwdata = 8'h66;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 preset = 1'b0;
    #1;
    n_vec++; if (pready1 !== 1'b0) begin n_err++; $display("FAIL mid_wait_pready got=%b want=0", pready1); end
    @(posedge clk); #1;
    psel1 = 1'b0; penable = 1'b0; preset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 1'b0, raddr[i], 8'h00, cyc, rd, err, post);
      n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL mid_clear_rd%h got=%h want=00", raddr[i], rd); end
    end
    xfer(1'b1, 1'b0, 8'h01, 8'h00, cyc, rd, err, post);
    n_vec++; if (rd !== 8'h00) begin n_err++; $display("FAIL mid_clear_dut0_rd01 got=%h want=00", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_resetup();
    test_out_of_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
